stream_mux_rr: RTL
==================

# stream_mux_rr

Parametrised M-input, N-bit stream multiplexer with valid/ready handshakes, run-time selectable round-robin or fixed-priority arbitration, and a registered output stage. It merges several symbol sources of the Morse terminal, such as the key decoder, the UART receive path and the playback buffer, onto one shared downstream consumer. Each accepted word is tagged with the index of its source channel.

## Interface
Parameters:
- N, 8, data width per channel in bits (≥1)
- M, 4, number of input channels (≥1)
- SEL_W, clog2(M) with a minimum of 1, width of the grant index (derived)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  asynchronous active-low reset
- mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
- in_data  input  M*N  channel i occupies bits [i*N +: N]
- in_valid  input  M  per-channel valid
- in_ready  output  M  per-channel ready (one-hot or zero)
- out_data  output  N  registered output word
- out_valid  output  1  out_data holds an unconsumed word
- out_sel  output  SEL_W  source channel index of out_data
- out_ready  input  1  downstream accepts the word when high together with out_valid

## Operation
- Load enable: load = ~out_valid | out_ready.
- Grant:
  - The grant g is computed combinationally from in_valid.
  - Round-robin: g is the first channel with in_valid=1, searching upward from ptr and wrapping from M-1 to 0.
  - Fixed priority: g is the lowest index with in_valid=1.
- in_ready[g] = load & (a request exists). All other in_ready bits are 0, and at most one bit is ever high.
- Transfer on channel g: in_valid[g] & in_ready[g]. On a transfer:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
- Consume without refill: when out_valid & out_ready and no request exists, out_valid <= 0. out_data and out_sel keep their last values.
- Pointer ptr (SEL_W bits):
  - Updated only on a transfer in round-robin mode: ptr <= (g == M-1) ? 0 : g+1.
  - Held in fixed-priority mode and on cycles without a transfer.
- Combinational paths: in_ready depends on out_ready and in_valid. Sources must not make in_valid depend on in_ready. A source must hold in_valid and in_data stable until its transfer.
- M=1: g is always 0, ptr stays 0, and the block degenerates to a one-stage register slice.

## Timing
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, out_sel=0, ptr=0
  - in_ready=0 while reset_n is low
- Latency: a word accepted in cycle t is visible on out_data/out_valid in cycle t+1.
- Throughput: one word per cycle when out_ready is held high. Consume and refill happen in the same cycle with no bubble.
- Backpressure: while out_valid=1 and out_ready=0, all in_ready bits are 0, and out_data and out_sel hold.
- Mode change: takes effect in the same cycle, since arbitration is combinational. ptr is preserved across mode changes.
- Reset mid-operation: a held word is discarded, and ptr returns to 0.
- No requests: out_valid drains normally, and ptr is unchanged.

## Structure
- Shared package/header `stream_mux_pkg`: the clog2 constant function and the SEL_W derivation rule.
- Sub-module `rr_arbiter`, parametrised by M:
  - Inputs: req, ptr, mode.
  - Outputs: one-hot grant, encoded index, any_req.
- The top level holds the output register, the pointer register and the data select.

## Test plan
- Reset: with reset_n=0, drive all in_valid=1 -> in_ready=0, out_valid=0, out_sel=0. After release, the first transfer is from channel 0.
- Round-robin fairness: N=8, M=4, mode=0, all channels valid continuously with data 8'hA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,… and one word per cycle.
- Fixed priority: mode=1, channels 1 and 3 valid, out_ready=1 -> every transfer is from channel 1 and channel 3 starves. Drop channel 1 -> channel 3 is granted in the next cycle.
- Backpressure: out_ready=0 for 5 cycles with channel 2 valid, data 8'h5C -> out_data holds 8'h5C, in_ready=0 throughout. Raise out_ready -> the next word is loaded in that same cycle.
- Wrap and skip: mode=0, ptr=3 after a grant to channel 2, only channel 1 valid -> channel 1 is granted and ptr becomes 2.
- Mid-operation reset: pulse reset_n low while out_valid=1 -> out_valid=0 immediately (asynchronous), and ptr=0 after release.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
// Grant index width is clog2(M) but never narrower than one bit.
package stream_mux_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int sel_w(input int m);
        return (clog2(m) < 1) ? 1 : clog2(m);
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between M stream sources and the single merged output.
// slave is the multiplexer's view, master is the view of whatever drives it.
interface stream_mux_rr_if
    import stream_mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int SEL_W = sel_w(M)
);
    logic [M*N-1:0]   in_data;
    logic [M-1:0]     in_valid;
    logic [M-1:0]     in_ready;
    logic [N-1:0]     out_data;
    logic             out_valid;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational arbiter: round-robin search upward from ptr with wrap,
// or fixed priority (lowest index) when mode is high.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int M     = 4,
    parameter int SEL_W = sel_w(M)
) (
    input  logic [M-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic             mode_i,
    output logic [M-1:0]     grant_o,
    output logic [SEL_W-1:0] idx_o,
    output logic             any_req_o
);
    int   cand;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < M; k++) begin
            cand = mode_i ? k : ((int'(ptr_i) + k) % M);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = SEL_W'(cand);
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/stream_mux_rr.sv
// M-input stream multiplexer with a registered output stage; each word
// carries the index of the channel it came from.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int SEL_W = sel_w(M)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            mode,
    stream_mux_rr_if.slave  bus
);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(M - 1);

    logic [N-1:0]     data_q,  data_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;

    logic [M-1:0]     grant;
    logic [SEL_W-1:0] g_idx;
    logic             any_req;
    logic             load;
    logic             xfer;

    rr_arbiter #(.M(M), .SEL_W(SEL_W)) u_arb (
        .req_i     (bus.in_valid),
        .ptr_i     (ptr_q),
        .mode_i    (mode),
        .grant_o   (grant),
        .idx_o     (g_idx),
        .any_req_o (any_req)
    );

    assign load = ~valid_q | bus.out_ready;
    assign xfer = load & any_req;

    // reset_n gates ready so no source sees a handshake while reset is held
    assign bus.in_ready = (reset_n & xfer) ? grant : '0;

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            data_d  = bus.in_data[int'(g_idx)*N +: N];
            sel_d   = g_idx;
            valid_d = 1'b1;
            if (!mode) begin
                ptr_d = (g_idx == LAST_IDX) ? '0 : g_idx + 1'b1;
            end
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;

endmodule
